// File: rtl/pill_sched_pkg.sv
// rtl/pill_sched_pkg.sv - shared types and constants for the pill schedule writer
package pill_sched_pkg;

    localparam int SCHED_W = 28;

    // Control FSM load state; the monitor re-reads durations when control returns here
    localparam logic [3:0] RELOAD_STATE = 4'd0;

    // Nibble offsets of each field inside the schedule word
    localparam int OFF_PROF = 24;
    localparam int OFF_ID1  = 20;
    localparam int OFF_DUR1 = 16;
    localparam int OFF_ID2  = 12;
    localparam int OFF_DUR2 = 8;
    localparam int OFF_ID3  = 4;
    localparam int OFF_DUR3 = 0;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_PROF    = 4'd1,
        ST_ID1     = 4'd2,
        ST_DUR1    = 4'd3,
        ST_ID2     = 4'd4,
        ST_DUR2    = 4'd5,
        ST_ID3     = 4'd6,
        ST_DUR3    = 4'd7,
        ST_CONFIRM = 4'd8,
        ST_WRITE   = 4'd9,
        ST_DONE    = 4'd10
    } state_t;

    // Bit offset of the nibble that a field index (0..6) writes
    function automatic logic [4:0] field_offset(input logic [2:0] field);
        logic [4:0] off;
        case (field)
            3'd0:    off = 5'(OFF_PROF);
            3'd1:    off = 5'(OFF_ID1);
            3'd2:    off = 5'(OFF_DUR1);
            3'd3:    off = 5'(OFF_ID2);
            3'd4:    off = 5'(OFF_DUR2);
            3'd5:    off = 5'(OFF_ID3);
            default: off = 5'(OFF_DUR3);
        endcase
        return off;
    endfunction

    // Display cursor for a state: fields 0..6, 7 once all fields are entered
    function automatic logic [2:0] field_of(input state_t st);
        logic [2:0] f;
        case (st)
            ST_PROF:    f = 3'd0;
            ST_ID1:     f = 3'd1;
            ST_DUR1:    f = 3'd2;
            ST_ID2:     f = 3'd3;
            ST_DUR2:    f = 3'd4;
            ST_ID3:     f = 3'd5;
            ST_DUR3:    f = 3'd6;
            ST_CONFIRM: f = 3'd7;
            ST_WRITE:   f = 3'd7;
            ST_DONE:    f = 3'd7;
            default:    f = 3'd0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/pill_field_check.sv
// rtl/pill_field_check.sv - combinational legality check for one schedule field
module pill_field_check
    import pill_sched_pkg::*;
(
    input  logic [2:0]         field,
    input  logic [3:0]         value,
    input  logic [SCHED_W-1:0] staged,
    input  logic [3:0]         max_interval,
    output logic               accept
);

    logic [3:0] id1;
    logic [3:0] id2;
    logic       interval_ok;

    assign id1 = staged[OFF_ID1 +: 4];
    assign id2 = staged[OFF_ID2 +: 4];

    // Zero is the monitor's reload marker, so it is never a legal interval
    assign interval_ok = (value != 4'd0) && (value <= max_interval);

    // Ids only compare against pills entered before this one; later nibbles may be stale
    always_comb begin
        accept = 1'b0;
        case (field)
            3'd0:    accept = 1'b1;
            3'd1:    accept = (value != 4'd0);
            3'd3:    accept = (value != 4'd0) && (value != id1);
            3'd5:    accept = (value != 4'd0) && (value != id1) && (value != id2);
            3'd2,
            3'd4,
            3'd6:    accept = interval_ok;
            default: accept = 1'b0;
        endcase
    end

endmodule

// File: rtl/pill_schedule_writer.sv
// rtl/pill_schedule_writer.sv - front-panel programming FSM that stages and writes the schedule word
module pill_schedule_writer
    import pill_sched_pkg::*;
#(
    parameter logic [3:0] MAX_INTERVAL = 4'd12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         value,
    input  logic               start,
    input  logic               enter,
    input  logic               back,
    input  logic               wr_ack,
    output logic               wr_en,
    output logic [SCHED_W-1:0] wr_data,
    output logic [2:0]         field_idx,
    output logic               busy,
    output logic               err,
    output logic               reload_req
);

    state_t             state;
    state_t             state_next;
    logic [SCHED_W-1:0] staged_next;
    logic               err_next;
    logic [2:0]         cur_field;
    logic               accept;

    assign cur_field = field_of(state);

    pill_field_check u_check (
        .field        (cur_field),
        .value        (value),
        .staged       (wr_data),
        .max_interval (MAX_INTERVAL),
        .accept       (accept)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, staged word and error flag; back has priority over enter
    always_comb begin
        state_next  = state;
        staged_next = wr_data;
        err_next    = err;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next  = ST_PROF;
                    staged_next = '0;
                    err_next    = 1'b0;
                end
            end
            ST_PROF, ST_ID1, ST_DUR1, ST_ID2, ST_DUR2, ST_ID3, ST_DUR3: begin
                if (back) begin
                    err_next = 1'b0;
                    case (state)
                        ST_PROF: state_next = ST_IDLE;
                        ST_ID1:  state_next = ST_PROF;
                        ST_DUR1: state_next = ST_ID1;
                        ST_ID2:  state_next = ST_DUR1;
                        ST_DUR2: state_next = ST_ID2;
                        ST_ID3:  state_next = ST_DUR2;
                        default: state_next = ST_ID3;
                    endcase
                end else if (enter) begin
                    if (accept) begin
                        err_next = 1'b0;
                        staged_next[field_offset(cur_field) +: 4] = value;
                        case (state)
                            ST_PROF: state_next = ST_ID1;
                            ST_ID1:  state_next = ST_DUR1;
                            ST_DUR1: state_next = ST_ID2;
                            ST_ID2:  state_next = ST_DUR2;
                            ST_DUR2: state_next = ST_ID3;
                            ST_ID3:  state_next = ST_DUR3;
                            default: state_next = ST_CONFIRM;
                        endcase
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_CONFIRM: begin
                if (back) begin
                    state_next = ST_DUR3;
                    err_next   = 1'b0;
                end else if (enter) begin
                    state_next = ST_WRITE;
                    err_next   = 1'b0;
                end
            end
            ST_WRITE: begin
                if (wr_ack) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered outputs decoded from the next state so they line up with the state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            wr_data    <= '0;
            field_idx  <= 3'd0;
            busy       <= 1'b0;
            err        <= 1'b0;
            reload_req <= 1'b0;
        end else begin
            wr_en      <= (state_next == ST_WRITE);
            wr_data    <= staged_next;
            field_idx  <= field_of(state_next);
            busy       <= (state_next != ST_IDLE);
            err        <= err_next;
            reload_req <= (state_next == ST_DONE);
        end
    end

endmodule

// File: tb/tb_pill_schedule_writer.sv
// tb/tb_pill_schedule_writer.sv - directed self-checking bench for pill_schedule_writer
module tb_pill_schedule_writer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  value;
    logic        start;
    logic        enter;
    logic        back;
    logic        wr_ack;
    logic        wr_en;
    logic [27:0] wr_data;
    logic [2:0]  field_idx;
    logic        busy;
    logic        err;
    logic        reload_req;

    int checks;
    int failures;

    pill_schedule_writer #(.MAX_INTERVAL(4'd12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .start      (start),
        .enter      (enter),
        .back       (back),
        .wr_ack     (wr_ack),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .field_idx  (field_idx),
        .busy       (busy),
        .err        (err),
        .reload_req (reload_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All pulse tasks start and finish on a falling edge
    task automatic do_enter(input logic [3:0] v);
        value = v;
        enter = 1'b1;
        @(negedge clk);
        enter = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_back();
        back = 1'b1;
        @(negedge clk);
        back = 1'b0;
    endtask

    logic [27:0] held;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        value    = 4'd0;
        start    = 1'b0;
        enter    = 1'b0;
        back     = 1'b0;
        wr_ack   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_field_idx", 32'(field_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_reload", 32'(reload_req), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Happy path: 2,1,4,2,8,3,6
        do_start();
        check("hp_busy", 32'(busy), 32'd1);
        check("hp_idx0", 32'(field_idx), 32'd0);
        do_enter(4'd2);
        do_enter(4'd1);
        do_enter(4'd4);
        do_enter(4'd2);
        do_enter(4'd8);
        do_enter(4'd3);
        check("hp_idx6", 32'(field_idx), 32'd6);
        do_enter(4'd6);
        check("hp_idx_confirm", 32'(field_idx), 32'd7);
        check("hp_word", 32'(wr_data), 32'h2142836);
        check("hp_wr_en_pre", 32'(wr_en), 32'd0);
        do_enter(4'd0);
        check("hp_wr_en_rise", 32'(wr_en), 32'd1);
        @(negedge clk);
        check("hp_wr_en_hold", 32'(wr_en), 32'd1);
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        check("hp_wr_en_fall", 32'(wr_en), 32'd0);
        check("hp_reload_hi", 32'(reload_req), 32'd1);
        check("hp_done_idx", 32'(field_idx), 32'd7);
        @(negedge clk);
        check("hp_reload_lo", 32'(reload_req), 32'd0);
        check("hp_idle_busy", 32'(busy), 32'd0);
        check("hp_word_kept", 32'(wr_data), 32'h2142836);

        // Illegal intervals, duplicate ids, back navigation
        do_start();
        check("ii_word_clr", 32'(wr_data), 32'd0);
        do_enter(4'd1);
        do_enter(4'd5);
        do_enter(4'd0);
        check("ii_zero_err", 32'(err), 32'd1);
        check("ii_zero_idx", 32'(field_idx), 32'd2);
        do_enter(4'd13);
        check("ii_13_err", 32'(err), 32'd1);
        check("ii_13_idx", 32'(field_idx), 32'd2);
        check("ii_13_word", 32'(wr_data), 32'h1500000);
        do_enter(4'd12);
        check("ii_12_err", 32'(err), 32'd0);
        check("ii_12_idx", 32'(field_idx), 32'd3);
        check("ii_12_nib", 32'(wr_data[19:16]), 32'hC);
        do_enter(4'd5);
        check("dup_err", 32'(err), 32'd1);
        check("dup_idx", 32'(field_idx), 32'd3);
        do_enter(4'd7);
        check("dup_ok_err", 32'(err), 32'd0);
        check("dup_ok_idx", 32'(field_idx), 32'd4);
        do_start();
        check("start_ignored", 32'(field_idx), 32'd4);
        do_back();
        check("bk_idx", 32'(field_idx), 32'd3);
        do_enter(4'd9);
        check("bk_reenter_idx", 32'(field_idx), 32'd4);
        check("bk_reenter_word", 32'(wr_data), 32'h15C9000);
        value = 4'd3;
        enter = 1'b1;
        back  = 1'b1;
        @(negedge clk);
        enter = 1'b0;
        back  = 1'b0;
        check("bk_wins_idx", 32'(field_idx), 32'd3);
        check("bk_wins_word", 32'(wr_data), 32'h15C9000);
        do_back();
        do_back();
        do_back();
        check("bk_prof_idx", 32'(field_idx), 32'd0);
        check("bk_prof_busy", 32'(busy), 32'd1);
        do_back();
        check("bk_abort_busy", 32'(busy), 32'd0);

        // Slow ack with a duplicate third id on the way
        do_start();
        do_enter(4'd0);
        do_enter(4'd1);
        do_enter(4'd1);
        do_enter(4'd2);
        do_enter(4'd2);
        do_enter(4'd1);
        check("dup3_err", 32'(err), 32'd1);
        check("dup3_idx", 32'(field_idx), 32'd5);
        do_enter(4'd3);
        do_enter(4'd3);
        do_enter(4'd0);
        held = 28'h0112233;
        for (int i = 0; i < 20; i++) begin
            start = (i % 3 == 0);
            enter = (i % 3 == 1);
            back  = (i % 3 == 2);
            value = 4'd9;
            @(negedge clk);
            start = 1'b0;
            enter = 1'b0;
            back  = 1'b0;
            check("sa_wr_en", 32'(wr_en), 32'd1);
            check("sa_wr_data", 32'(wr_data), 32'(held));
            check("sa_idx", 32'(field_idx), 32'd7);
        end
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        check("sa_reload_hi", 32'(reload_req), 32'd1);
        check("sa_wr_en_fall", 32'(wr_en), 32'd0);
        @(negedge clk);
        check("sa_reload_lo", 32'(reload_req), 32'd0);
        check("sa_idle", 32'(busy), 32'd0);

        // Reset while waiting for ack
        do_start();
        do_enter(4'd2);
        do_enter(4'd1);
        do_enter(4'd4);
        do_enter(4'd2);
        do_enter(4'd8);
        do_enter(4'd3);
        do_enter(4'd6);
        do_enter(4'd0);
        check("mr_wr_en", 32'(wr_en), 32'd1);
        #2;
        rst_n  = 1'b0;
        wr_ack = 1'b1;
        #1;
        check("mr_wr_en_async", 32'(wr_en), 32'd0);
        check("mr_wr_data", 32'(wr_data), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_idx", 32'(field_idx), 32'd0);
        check("mr_err", 32'(err), 32'd0);
        check("mr_reload", 32'(reload_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mr_no_reload", 32'(reload_req), 32'd0);
            check("mr_idle", 32'(busy), 32'd0);
        end
        wr_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
